hamming_serial_tx: RTL and testbench

Transmit side of the team's Hamming-protected counter path. Captures a counter snapshot and encodes each 4-bit nibble into a 7-bit Hamming codeword using the same parity equations as the counter's correction logic. Serializes the codewords LSB-first over a valid/ready bit stream, so a downstream receiver can run syndrome decode and single-bit correction per nibble.

---
 rtl/hamming_pkg.sv | 28 ++
 rtl/hamming_nibble_enc.sv | 11 +
 rtl/hamming_serial_tx.sv | 91 +++++++++
 tb/tb_hamming_serial_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming-protected counter transmit path:
// nibble encoder, transmitter state encoding and frame-size helper.
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    localparam int unsigned NIBBLE_CODE_BITS = 7;

    function automatic int unsigned code_bits_for(input int unsigned w);
        return (w / 4) * NIBBLE_CODE_BITS;
    endfunction

    // Codeword in frame order: bit 0 = d0 ... bit 3 = d3, then p0, p1, p2.
    function automatic logic [6:0] enc_nibble(input logic [3:0] d);
        logic p0;
        logic p1;
        logic p2;
        p0 = d[0] ^ d[2] ^ d[3];
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[1] ^ d[2];
        return {p2, p1, p0, d};
    endfunction

endpackage

// File: rtl/hamming_nibble_enc.sv
// Combinational 4-to-7 Hamming encoder for a single nibble.
module hamming_nibble_enc
    import hamming_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    assign code = enc_nibble(nibble);

endmodule

// File: rtl/hamming_serial_tx.sv
// Hamming-encodes a counter snapshot and streams it LSB-first over valid/ready.
// Optional HAMMING_TX_FAULT_INJ_EN adds a single-bit fault injection port pair.
module hamming_serial_tx
    import hamming_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] data_in,
`ifdef HAMMING_TX_FAULT_INJ_EN
    input  logic             inj_en,
    input  logic [$clog2(code_bits_for(width))-1:0] inj_pos,
`endif
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned blocks    = width / 4;
    localparam int unsigned code_bits = code_bits_for(width);
    localparam int unsigned cnt_w     = $clog2(code_bits);

    logic [code_bits-1:0] code_word;
    logic [code_bits-1:0] frame_word;
    logic [code_bits-1:0] shift_q;
    logic [cnt_w-1:0]     cnt_q;
    tx_state_t            state_q;

    for (genvar i = 0; i < blocks; i++) begin : g_enc
        hamming_nibble_enc u_enc (
            .nibble (data_in[i*4 +: 4]),
            .code   (code_word[i*7 +: 7])
        );
    end

`ifdef HAMMING_TX_FAULT_INJ_EN
    // Positions at or beyond code_bits match no bit, so the frame stays clean.
    always_comb begin
        frame_word = code_word;
        for (int j = 0; j < int'(code_bits); j++) begin
            if (inj_en && (inj_pos == cnt_w'(j))) begin
                frame_word[j] = ~code_word[j];
            end
        end
    end
`else
    assign frame_word = code_word;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= frame_word;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (ser_ready) begin
                        shift_q <= {1'b0, shift_q[code_bits-1:1]};
                        if (cnt_q == cnt_w'(code_bits - 1)) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign ser_valid   = (state_q == SEND);
    assign ser_out     = ser_valid & shift_q[0];
    assign frame_start = ser_valid && (cnt_q == '0);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Directed bench for hamming_serial_tx with a bit-level expected-frame scoreboard.
module tb_hamming_serial_tx;

    localparam int W  = 32;
    localparam int CB = 56;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic        ready;
    logic        ser_out;
    logic        ser_valid;
    logic        ser_ready;
    logic        frame_start;
    logic        done;
`ifdef HAMMING_TX_FAULT_INJ_EN
    logic        inj_en;
    logic [5:0]  inj_pos;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit sb[$];

    always #5 clk = ~clk;

    hamming_serial_tx #(.width(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
`ifdef HAMMING_TX_FAULT_INJ_EN
        .inj_en      (inj_en),
        .inj_pos     (inj_pos),
`endif
        .ready       (ready),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .ser_ready   (ser_ready),
        .frame_start (frame_start),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_ser_out"}, ser_out, 0);
        check({tag, "_ser_valid"}, ser_valid, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Expected frame: per nibble d0..d3, p0, p1, p2; optional flip at inj position.
    task automatic push_frame(input logic [31:0] d, input bit en, input int pos);
        logic [3:0] nib;
        bit b[7];
        for (int i = 0; i < W / 4; i++) begin
            nib  = d[i*4 +: 4];
            b[0] = nib[0];
            b[1] = nib[1];
            b[2] = nib[2];
            b[3] = nib[3];
            b[4] = nib[0] ^ nib[2] ^ nib[3];
            b[5] = nib[0] ^ nib[1] ^ nib[3];
            b[6] = nib[0] ^ nib[1] ^ nib[2];
            for (int k = 0; k < 7; k++) begin
                sb.push_back((en && (i * 7 + k == pos)) ? ~b[k] : b[k]);
            end
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle (unless aborted by reset).
    task automatic run_frame(input logic [31:0] d, input int stall_bit, input int stall_len,
                             input int pulse_bit, input int abort_bit);
        int n = 0;
        int r = 0;
        int stalls = 0;
        check("ready_before_start", ready, 1);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = ~d;
        while (sb.size() > 0) begin
            if (r > 300) begin
                n_tests++;
                n_fail++;
                $error("FAIL frame_timeout: observed %0d cycles expected %0d", r, CB + stall_len);
                sb.delete();
                break;
            end
            if (n == abort_bit) begin
                reset = 1'b1;
                #1;
                check_reset_outputs("abort");
                sb.delete();
                return;
            end
            check($sformatf("valid_bit%0d", n), ser_valid, 1);
            check($sformatf("data_bit%0d", n), ser_out, sb[0]);
            check($sformatf("frame_start_bit%0d", n), frame_start, n == 0);
            check($sformatf("done_low_bit%0d", n), done, 0);
            start = (n == pulse_bit);
            if (n == stall_bit && stalls < stall_len) begin
                ser_ready = 1'b0;
                stalls++;
            end else begin
                ser_ready = 1'b1;
                void'(sb.pop_front());
                n++;
            end
            @(posedge clk);
            #1;
            r++;
        end
        start     = 1'b0;
        ser_ready = 1'b1;
        check("done_cycle", r, CB + stall_len);
        check("done_pulse", done, 1);
        check("done_ready", ready, 0);
        check("done_valid", ser_valid, 0);
        check("done_ser_out", ser_out, 0);
        // start during DONE must be ignored
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_ready", ready, 1);
        check("idle_done", done, 0);
        check("idle_valid", ser_valid, 0);
        @(posedge clk);
        #1;
        check("still_idle_ready", ready, 1);
        check("still_idle_valid", ser_valid, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        ser_ready = 1'b1;
        data_in   = '0;
`ifdef HAMMING_TX_FAULT_INJ_EN
        inj_en    = 1'b0;
        inj_pos   = '0;
`endif
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("post_reset");

        push_frame(32'h0000_0000, 1'b0, 0);
        run_frame(32'h0000_0000, -1, 0, -1, -1);

        push_frame(32'h0000_0001, 1'b0, 0);
        run_frame(32'h0000_0001, -1, 0, -1, -1);

        push_frame(32'h0000_000F, 1'b0, 0);
        run_frame(32'h0000_000F, -1, 0, -1, -1);

        push_frame(32'hA5C3_1E96, 1'b0, 0);
        run_frame(32'hA5C3_1E96, 10, 3, 30, -1);

        push_frame(32'h1234_5678, 1'b0, 0);
        run_frame(32'h1234_5678, -1, 0, -1, 20);
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        push_frame(32'h0000_0001, 1'b0, 0);
        run_frame(32'h0000_0001, -1, 0, -1, -1);

`ifdef HAMMING_TX_FAULT_INJ_EN
        inj_en  = 1'b1;
        inj_pos = 6'd3;
        push_frame(32'h0000_0001, 1'b1, 3);
        run_frame(32'h0000_0001, -1, 0, -1, -1);

        inj_pos = 6'd60;
        push_frame(32'h0000_0001, 1'b1, 60);
        run_frame(32'h0000_0001, -1, 0, -1, -1);
        inj_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
